// File: rtl/vm2002_common_pkg.sv
// vm2002_common_pkg
// Shared types and constants for the vm2002 vending machine.
// Holds the coin encoding, the change-payout FSM states and result codes,
// and the coin face values in cents.
package vm2002_common_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        NICKEL  = 2'b01,
        DIME    = 2'b10,
        QUARTER = 2'b11
    } coins_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SELECT = 2'b01,
        EJECT  = 2'b10,
        DONE   = 2'b11
    } chg_state_t;

    typedef enum logic [1:0] {
        OK    = 2'b00,
        SHORT = 2'b01,
        JAM   = 2'b10,
        ABORT = 2'b11
    } chg_status_t;

    localparam int NICKEL_VAL  = 5;
    localparam int DIME_VAL    = 10;
    localparam int QUARTER_VAL = 25;

endpackage

// File: rtl/vm2002_coin_tube.sv
// vm2002_coin_tube
// Fill-level counter for one coin tube. Each cycle the level moves by
// load + inc - dec and saturates at the all-ones value.
// Ports:
//   clk      in   clock
//   hrst_n   in   asynchronous active-low reset (level -> 0)
//   load_i   in   LVL_W  coins added by a supplier refill this cycle
//   inc_i    in   1      one coin accepted from the user this cycle
//   dec_i    in   1      one coin ejected this cycle
//   level_o  out  LVL_W  current fill level
module vm2002_coin_tube #(
    parameter int LVL_W = 8
) (
    input  logic             clk,
    input  logic             hrst_n,
    input  logic [LVL_W-1:0] load_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [LVL_W-1:0] level_o
);

    localparam int SUM_W = LVL_W + 2;
    localparam logic [SUM_W-1:0] MAX_LVL = SUM_W'({LVL_W{1'b1}});

    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic [SUM_W-1:0] sum;

    // Two guard bits hold level + load + inc without wrapping. The FSM only
    // picks a coin from a non-empty tube, so the subtraction cannot go negative.
    always_comb begin
        sum = {2'b00, level_q} + {2'b00, load_i} + SUM_W'(inc_i) - SUM_W'(dec_i);
        if (sum > MAX_LVL) begin
            level_d = {LVL_W{1'b1}};
        end else begin
            level_d = sum[LVL_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/vm2002_change_ctrl.sv
// vm2002_change_ctrl
// Change-payout controller. Pays a balance out greedily as quarters, dimes and
// nickels through a valid/ack handshake with the coin hopper, and tracks the
// fill levels of the three coin tubes.
// Ports:
//   clk, hrst_n, srst           clock, async active-low reset, sync soft reset
//   req, amount, ready          payout request (accepted when req && ready)
//   coin_in                     coin accepted from the user this cycle
//   load_valid/coin/count       supplier refill
//   eject_valid/coin/ack        hopper handshake, one coin per transfer
//   done, status, remaining     completion pulse and latched result
//   lvl_q, lvl_d, lvl_n         quarter / dime / nickel tube levels
module vm2002_change_ctrl
    import vm2002_common_pkg::*;
#(
    parameter int AMT_W   = 16,
    parameter int LVL_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             hrst_n,
    input  logic             srst,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    output logic             ready,
    input  logic [1:0]       coin_in,
    input  logic             load_valid,
    input  logic [1:0]       load_coin,
    input  logic [LVL_W-1:0] load_count,
    output logic             eject_valid,
    output logic [1:0]       eject_coin,
    input  logic             eject_ack,
    output logic             done,
    output logic [1:0]       status,
    output logic [AMT_W-1:0] remaining,
    output logic [LVL_W-1:0] lvl_q,
    output logic [LVL_W-1:0] lvl_d,
    output logic [LVL_W-1:0] lvl_n
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    chg_state_t       state_q;
    chg_status_t      status_q;
    coins_t           eject_coin_q;
    logic [AMT_W-1:0] rem_q;
    logic [AMT_W-1:0] remaining_q;
    logic [TMR_W-1:0] timer_q;

    logic [LVL_W-1:0] levels [3];
    logic             ack_take;
    logic [AMT_W-1:0] eject_val;
    logic             pick_q, pick_d, pick_n;

    // An ack that coincides with a soft reset is dropped, so the tube is not
    // decremented for a coin the FSM never accounts for.
    assign ack_take = (state_q == EJECT) && eject_ack && !srst;

    // Tube gi holds coin type gi+1: 0 = nickel, 1 = dime, 2 = quarter.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tube
            localparam logic [1:0] TUBE_COIN = 2'(gi + 1);
            logic [LVL_W-1:0] tube_load;
            assign tube_load = (load_valid && load_coin == TUBE_COIN) ? load_count : '0;

            vm2002_coin_tube #(.LVL_W(LVL_W)) u_tube (
                .clk     (clk),
                .hrst_n  (hrst_n),
                .load_i  (tube_load),
                .inc_i   (coin_in == TUBE_COIN),
                .dec_i   (ack_take && (eject_coin_q == TUBE_COIN)),
                .level_o (levels[gi])
            );
        end
    endgenerate

    assign lvl_n = levels[0];
    assign lvl_d = levels[1];
    assign lvl_q = levels[2];

    always_comb begin
        eject_val = '0;
        case (eject_coin_q)
            NICKEL:  eject_val = AMT_W'(NICKEL_VAL);
            DIME:    eject_val = AMT_W'(DIME_VAL);
            QUARTER: eject_val = AMT_W'(QUARTER_VAL);
            default: eject_val = '0;
        endcase
    end

    // Greedy candidates; the FSM applies quarter > dime > nickel priority.
    assign pick_q = (rem_q >= AMT_W'(QUARTER_VAL)) && (lvl_q != '0);
    assign pick_d = (rem_q >= AMT_W'(DIME_VAL))    && (lvl_d != '0);
    assign pick_n = (rem_q >= AMT_W'(NICKEL_VAL))  && (lvl_n != '0);

    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_q      <= IDLE;
            status_q     <= OK;
            eject_coin_q <= NONE;
            rem_q        <= '0;
            remaining_q  <= '0;
            timer_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && !srst) begin
                        rem_q   <= amount;
                        state_q <= SELECT;
                    end
                end
                SELECT: begin
                    timer_q <= '0;
                    if (srst) begin
                        status_q    <= ABORT;
                        remaining_q <= rem_q;
                        state_q     <= DONE;
                    end else if (pick_q) begin
                        eject_coin_q <= QUARTER;
                        state_q      <= EJECT;
                    end else if (pick_d) begin
                        eject_coin_q <= DIME;
                        state_q      <= EJECT;
                    end else if (pick_n) begin
                        eject_coin_q <= NICKEL;
                        state_q      <= EJECT;
                    end else begin
                        status_q    <= (rem_q == '0) ? OK : SHORT;
                        remaining_q <= rem_q;
                        state_q     <= DONE;
                    end
                end
                EJECT: begin
                    timer_q <= timer_q + TMR_W'(1);
                    if (srst) begin
                        status_q    <= ABORT;
                        remaining_q <= rem_q;
                        state_q     <= DONE;
                    end else if (eject_ack) begin
                        // Ack has priority over a timeout in the same cycle.
                        rem_q   <= rem_q - eject_val;
                        state_q <= SELECT;
                    end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        status_q    <= JAM;
                        remaining_q <= rem_q;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready       = (state_q == IDLE);
    assign eject_valid = (state_q == EJECT);
    assign done        = (state_q == DONE);
    assign eject_coin  = eject_coin_q;
    assign status      = status_q;
    assign remaining   = remaining_q;

endmodule

// File: doc/vm2002_change_ctrl.md
# vm2002_change_ctrl

Change-payout controller for the vm2002 vending machine. It accepts a balance (in cents) from the main vending FSM, then pays it out as quarters, dimes and nickels from three coin tubes, using a per-coin valid/ack handshake with the coin hopper. It also tracks tube fill levels: coins accepted from the user add to the tubes, supplier refills add to the tubes, and ejections subtract from them.

## Interface
Parameters:
- AMT_W, 16, width of amount/remaining (cents)
- LVL_W, 8, width of each tube level counter
- TIMEOUT, 255, cycles eject_valid may wait for eject_ack before a jam is declared

Ports:
- clk  in  1  clock; all state updates on the rising edge
- hrst_n  in  1  asynchronous, active-low reset
- srst  in  1  synchronous soft reset; aborts a payout, tube levels kept
- req  in  1  payout request; accepted when req && ready
- amount  in  AMT_W  balance to pay, sampled on acceptance
- ready  out  1  high only in IDLE
- coin_in  in  2  coin accepted from user this cycle (coins_t)
- load_valid  in  1  supplier refill strobe
- load_coin  in  2  tube to refill (coins_t; NONE ignored)
- load_count  in  LVL_W  coins added
- eject_valid  out  1  request the hopper to eject one coin
- eject_coin  out  2  coin type; stable while eject_valid is high
- eject_ack  in  1  hopper confirms the ejection; only meaningful while eject_valid is high
- done  out  1  one-cycle completion pulse
- status  out  2  chg_status_t result, valid from done until the next acceptance
- remaining  out  AMT_W  unpaid cents, valid with status
- lvl_q, lvl_d, lvl_n  out  LVL_W each  tube fill levels

## Operation
- coins_t encoding: NONE=00, NICKEL=01, DIME=10, QUARTER=11. Coin values are 5, 10 and 25 cents, zero-extended to AMT_W.
- chg_status_t encoding: OK=00, SHORT=01, JAM=10, ABORT=11.
- FSM states: IDLE, SELECT, EJECT, DONE.
- IDLE
  - ready=1.
  - req with srst low: latch rem=amount, then go to SELECT.
  - If srst is high, req is ignored.
- SELECT: greedy choice, evaluated in this priority order:
  - rem≥25 and lvl_q>0: pick QUARTER.
  - else rem≥10 and lvl_d>0: pick DIME.
  - else rem≥5 and lvl_n>0: pick NICKEL.
  - else go to DONE with status=OK if rem==0, otherwise SHORT.
  - When a coin is picked, register it into eject_coin, clear the timer, and go to EJECT.
- EJECT
  - eject_valid=1 and the timer increments each cycle.
  - On eject_ack: rem -= value, decrement the matching tube, go to SELECT.
  - If there is no ack and timer==TIMEOUT-1: go to DONE with status JAM; rem and the tube are unchanged.
  - If ack and the timeout occur in the same cycle, ack wins.
- DONE: done=1 for one cycle; status and remaining latched; go to IDLE.
- srst in SELECT or EJECT: go to DONE with status ABORT and remaining=rem.
  - An eject_ack arriving in the same cycle as srst is ignored: no decrement.
- Tube update, per tube, every cycle: next = level + load + coin_in_inc − eject_dec, saturating at 2^LVL_W−1.
  - Simultaneous increment and decrement of the same tube nets out.
  - Underflow is impossible: a coin is only picked when its level is above 0.
- Arithmetic: rem never underflows, because a coin is only picked when rem ≥ its value. Amounts not divisible by 5 always end SHORT, with remainder ≤ 4 when the tubes are ample.
- hrst_n low at any time forces the reset values (see Timing); an in-flight payout is lost and no done is produced.

## Timing
- Reset values: state=IDLE, ready=1, eject_valid=0, eject_coin=NONE, done=0, status=OK, remaining=0, all levels=0.
- Request accepted at edge T:
  - SELECT during cycle T+1.
  - First eject_valid in cycle T+2, or done in cycle T+2 if no coin can be paid.
- Each coin takes at least 2 cycles: one EJECT cycle with ack, then one SELECT cycle.
- amount=0 gives done with status OK 2 cycles after acceptance.
- All outputs are registered or decoded from state; there is no combinational path from an input to an output.
- Level outputs update the edge after the event that changes them.

## Structure
- Additions to vm2002_common_pkg: coins_t, chg_state_t, chg_status_t, and the coin-value constants NICKEL_VAL, DIME_VAL, QUARTER_VAL.
- Sub-module vm2002_coin_tube: a saturating LVL_W counter with load/inc/dec inputs, instantiated three times.
- Everything else (FSM, timer, rem register) lives in vm2002_change_ctrl.

## Test plan
- Tubes Q/D/N=4/4/4, req amount=40 (ack the cycle after each valid) → ejects QUARTER, DIME, NICKEL; done with status OK, remaining=0; levels 3/3/3.
- Tubes 0/1/1, amount=30 → ejects DIME, then NICKEL; done with status SHORT, remaining=15; levels 0/0/0.
- Tubes 4/4/4, amount=7 → ejects one NICKEL; done with status SHORT, remaining=2.
- TIMEOUT=8, amount=25, ack withheld → eject_valid high for 8 cycles, then done with status JAM, remaining=25, lvl_q unchanged.
- srst pulsed together with eject_ack on the second coin of amount=50 → done with status ABORT, remaining=25, lvl_q decremented only once.
- lvl_n=5: coin_in=NICKEL in the same cycle as a NICKEL ack → lvl_n stays 5. Then load 250 followed by load 10 into the DIME tube (from 0) → lvl_d=255, saturated.
